// File: rtl/jtag_pkg.sv
// jtag_pkg: shared constants and types for the JTAG test-data-register block.
// Holds the instruction opcodes, the IR capture pattern, the default
// parameter values used by jtag_tdr and the decoded-instruction enum.
// Optional feature macro used by jtag_tdr: JTAG_USER_DR_EN.
package jtag_pkg;

  localparam int          IR_WIDTH_DEFAULT     = 4;
  localparam logic [31:0] IDCODE_VALUE_DEFAULT = 32'h1A2B_3C4D;

  localparam logic [3:0] IR_BYPASS = 4'b1111;
  localparam logic [3:0] IR_IDCODE = 4'b0001;
  localparam logic [3:0] IR_USER   = 4'b1000;

  // Low two IR bits loaded on Capture_IR; upper bits are zero.
  localparam logic [1:0] IR_CAPTURE = 2'b01;

  typedef enum logic [1:0] {
    INSTR_BYPASS,
    INSTR_IDCODE,
    INSTR_USER
  } instr_e;

endpackage

// File: rtl/jtag_tdr_if.sv
// jtag_tdr_if: TAP-controller-to-data-register bundle.
// master: TAP side, drives tdi and the state strobes, receives tdo/tdo_oe.
// slave:  data-register side (jtag_tdr).
// Signals: tdi, tap_reset, select, enable, capture/shift/update_ir,
//          capture/shift/update_dr, tdo, tdo_oe.
interface jtag_tdr_if;
  import jtag_pkg::*;

  logic tdi;
  logic tap_reset;
  logic select;
  logic enable;
  logic capture_ir;
  logic shift_ir;
  logic update_ir;
  logic capture_dr;
  logic shift_dr;
  logic update_dr;
  logic tdo;
  logic tdo_oe;

  modport master (
    output tdi, tap_reset, select, enable,
    output capture_ir, shift_ir, update_ir,
    output capture_dr, shift_dr, update_dr,
    input  tdo, tdo_oe
  );

  modport slave (
    input  tdi, tap_reset, select, enable,
    input  capture_ir, shift_ir, update_ir,
    input  capture_dr, shift_dr, update_dr,
    output tdo, tdo_oe
  );

endinterface

// File: rtl/jtag_shift_reg.sv
// jtag_shift_reg: capture/shift chain with an optional parallel shadow.
// Ports:
//   tck, reset_n      clock and async active-low reset
//   clear             synchronous clear (shift reg -> 0, shadow -> UPDATE_RESET)
//   capture_en        load capture_val
//   shift_en          shift right, tdi enters at the MSB
//   update_en         copy shift reg into shadow (when HAS_UPDATE)
//   capture_val       parallel capture value
//   serial_out        bit 0 of the shift register
//   update_out        shadow register
// Priority: clear > capture > shift > update. WIDTH must be at least 2.
module jtag_shift_reg #(
  parameter int               WIDTH        = 8,
  parameter bit               HAS_UPDATE   = 1'b1,
  parameter logic [WIDTH-1:0] UPDATE_RESET = '0
) (
  input  logic             tck,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             capture_en,
  input  logic             shift_en,
  input  logic             update_en,
  input  logic             tdi,
  input  logic [WIDTH-1:0] capture_val,
  output logic             serial_out,
  output logic [WIDTH-1:0] update_out
);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] upd_q, upd_d;

  always_comb begin
    sr_d  = sr_q;
    upd_d = upd_q;
    if (clear) begin
      sr_d  = '0;
      upd_d = UPDATE_RESET;
    end else if (capture_en) begin
      sr_d = capture_val;
    end else if (shift_en) begin
      sr_d = {tdi, sr_q[WIDTH-1:1]};
    end else if (update_en && HAS_UPDATE) begin
      upd_d = sr_q;
    end
  end

  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      sr_q  <= '0;
      upd_q <= UPDATE_RESET;
    end else begin
      sr_q  <= sr_d;
      upd_q <= upd_d;
    end
  end

  assign serial_out = sr_q[0];
  assign update_out = upd_q;

endmodule

// File: rtl/jtag_tdr.sv
// jtag_tdr: JTAG instruction register, BYPASS/IDCODE/USER data registers
// and the negedge TDO output stage.
// Ports:
//   tck, reset_n   test clock and async active-low reset
//   tap            jtag_tdr_if.slave (tdi, TAP strobes, tdo, tdo_oe)
//   user_capture   parallel value loaded on USER capture
//   user_update    USER shadow register
//   user_strobe    one-tck pulse when user_update is loaded
//   ir_value       current IR shadow
// Macro JTAG_USER_DR_EN builds the USER register; without it opcode
// 4'b1000 decodes to BYPASS and the USER outputs are tied to zero.
module jtag_tdr
  import jtag_pkg::*;
#(
  parameter int          IR_WIDTH      = IR_WIDTH_DEFAULT,
  parameter int          USER_DR_WIDTH = 16,
  parameter logic [31:0] IDCODE_VALUE  = IDCODE_VALUE_DEFAULT
) (
  input  logic                     tck,
  input  logic                     reset_n,
  jtag_tdr_if.slave                tap,
  input  logic [USER_DR_WIDTH-1:0] user_capture,
  output logic [USER_DR_WIDTH-1:0] user_update,
  output logic                     user_strobe,
  output logic [IR_WIDTH-1:0]      ir_value
);

  instr_e instr;
  logic   ir_bit0, idcode_bit0, user_bit0;
  logic   cap_dr, sh_dr, up_dr;
  logic   bypass_q, bypass_d;
  logic   tdo_q, tdo_d, tdo_oe_q, tdo_oe_d;
  logic [31:0] idcode_upd_unused;

  // Resolve simultaneous DR strobes as capture > shift > update.
  assign cap_dr = tap.capture_dr;
  assign sh_dr  = tap.shift_dr & ~tap.capture_dr;
  assign up_dr  = tap.update_dr & ~tap.capture_dr & ~tap.shift_dr;

  jtag_shift_reg #(
    .WIDTH       (IR_WIDTH),
    .HAS_UPDATE  (1'b1),
    .UPDATE_RESET(IR_WIDTH'(IR_IDCODE))
  ) u_ir (
    .tck        (tck),
    .reset_n    (reset_n),
    .clear      (tap.tap_reset),
    .capture_en (tap.capture_ir),
    .shift_en   (tap.shift_ir),
    .update_en  (tap.update_ir),
    .tdi        (tap.tdi),
    .capture_val(IR_WIDTH'(IR_CAPTURE)),
    .serial_out (ir_bit0),
    .update_out (ir_value)
  );

  // Anything not IDCODE (or USER when built) selects BYPASS.
  always_comb begin
    instr = INSTR_BYPASS;
    if (ir_value == IR_WIDTH'(IR_IDCODE)) begin
      instr = INSTR_IDCODE;
    end
`ifdef JTAG_USER_DR_EN
    else if (ir_value == IR_WIDTH'(IR_USER)) begin
      instr = INSTR_USER;
    end
`endif
  end

  jtag_shift_reg #(
    .WIDTH     (32),
    .HAS_UPDATE(1'b0)
  ) u_idcode (
    .tck        (tck),
    .reset_n    (reset_n),
    .clear      (1'b0),
    .capture_en (cap_dr & (instr == INSTR_IDCODE)),
    .shift_en   (sh_dr & (instr == INSTR_IDCODE)),
    .update_en  (up_dr & (instr == INSTR_IDCODE)),
    .tdi        (tap.tdi),
    .capture_val(IDCODE_VALUE),
    .serial_out (idcode_bit0),
    .update_out (idcode_upd_unused)
  );

`ifdef JTAG_USER_DR_EN
  logic user_strobe_q, user_strobe_d;

  jtag_shift_reg #(
    .WIDTH     (USER_DR_WIDTH),
    .HAS_UPDATE(1'b1)
  ) u_user (
    .tck        (tck),
    .reset_n    (reset_n),
    .clear      (1'b0),
    .capture_en (cap_dr & (instr == INSTR_USER)),
    .shift_en   (sh_dr & (instr == INSTR_USER)),
    .update_en  (up_dr & (instr == INSTR_USER)),
    .tdi        (tap.tdi),
    .capture_val(user_capture),
    .serial_out (user_bit0),
    .update_out (user_update)
  );

  // Strobe rises on the same edge that loads user_update.
  always_comb begin
    user_strobe_d = up_dr & (instr == INSTR_USER);
  end

  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      user_strobe_q <= 1'b0;
    end else begin
      user_strobe_q <= user_strobe_d;
    end
  end

  assign user_strobe = user_strobe_q;
`else
  logic user_capture_unused;

  assign user_capture_unused = ^user_capture;
  assign user_bit0           = 1'b0;
  assign user_update         = '0;
  assign user_strobe         = 1'b0;
`endif

  always_comb begin
    bypass_d = bypass_q;
    if (instr == INSTR_BYPASS) begin
      if (cap_dr) begin
        bypass_d = 1'b0;
      end else if (sh_dr) begin
        bypass_d = tap.tdi;
      end
    end
  end

  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      bypass_q <= 1'b0;
    end else begin
      bypass_q <= bypass_d;
    end
  end

  always_comb begin
    tdo_oe_d = tap.enable;
    tdo_d    = bypass_q;
    if (tap.select) begin
      tdo_d = ir_bit0;
    end else begin
      case (instr)
        INSTR_IDCODE: tdo_d = idcode_bit0;
        INSTR_USER:   tdo_d = user_bit0;
        default:      tdo_d = bypass_q;
      endcase
    end
  end

  // TDO changes on the falling edge so the captured bit 0 is presented
  // before the first shifting rising edge.
  always_ff @(negedge tck or negedge reset_n) begin
    if (!reset_n) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_oe_q <= tdo_oe_d;
    end
  end

  assign tap.tdo    = tdo_q;
  assign tap.tdo_oe = tdo_oe_q;

endmodule
